// File: rtl/vga_fb_scan.sv
// VGA 640x480@60 scan-out: pixel timing, sequential frame-buffer reads on port B,
// registered RGB444 and sync outputs, plus vblank/frame_start for the generator.
module vga_fb_scan #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addrB,
  input  logic [11:0]       doutB,
  output logic              hs,
  output logic              vs,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              vblank,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  // Read data must settle inside one pixel period.
  if (RD_LAT >= PIX_DIV) begin : g_bad_lat
    $error("vga_fb_scan: RD_LAT must be smaller than PIX_DIV");
  end

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic pix_en_c;
  logic h_last_c;
  logic v_last_c;
  logic wrap_c;
  logic active_c;
  logic advance_c;
  logic hs_raw_c;
  logic vs_raw_c;

  always_comb begin
    pix_en_c = (div == DW'(PIX_DIV - 1));
    h_last_c = (hcnt == HW'(H_TOTAL - 1));
    v_last_c = (vcnt == VW'(V_TOTAL - 1));
    wrap_c   = h_last_c && v_last_c;
    active_c = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    // Step the address only when the pixel being entered is visible, so blanking
    // holds the address of the last visible pixel.
    advance_c = h_last_c ? (vcnt < VW'(V_ACTIVE - 1))
                         : (active_c && (hcnt < HW'(H_ACTIVE - 1)));
    hs_raw_c = !((hcnt >= HW'(HS_LO)) && (hcnt < HW'(HS_HI)));
    vs_raw_c = !((vcnt >= VW'(VS_LO)) && (vcnt < VW'(VS_HI)));
  end

  // Timing counters, read address and the one-pixel output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      addrB       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= pix_en_c ? '0 : div + DW'(1);
      frame_start <= pix_en_c && wrap_c;
      if (pix_en_c) begin
        hcnt <= h_last_c ? '0 : hcnt + HW'(1);
        if (h_last_c) begin
          vcnt <= v_last_c ? '0 : vcnt + VW'(1);
        end
        if (wrap_c) begin
          addrB <= '0;
        end else if (advance_c) begin
          addrB <= addrB + ADDR_W'(1);
        end
        // Colour, sync and vblank all describe the pixel just finished.
        {r, g, b} <= active_c ? doutB : 12'h000;
        hs        <= hs_raw_c;
        vs        <= vs_raw_c;
        vblank    <= (vcnt >= VW'(V_ACTIVE));
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scan.sv
// Bench for vga_fb_scan: a full-size instance for line-level timing and a shrunken
// instance for frame-level behaviour, both checked every clk against a time-based model.
module tb_vga_fb_scan;

  localparam int AW = 19;
  // full geometry
  localparam int F_HA = 640, F_HFP = 16, F_HS = 96, F_HBP = 48;
  localparam int F_VA = 480, F_VFP = 10, F_VS = 2, F_VBP = 33;
  // shrunken geometry: 15 px/line, 10 lines/frame, 600 clks/frame
  localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 6, S_VFP = 1, S_VS = 2, S_VBP = 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          hs;
    logic          vs;
    logic [11:0]   rgb;
    logic          vblank;
    logic          fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset_f = 1'b0;
  logic reset_s = 1'b0;

  logic [AW-1:0] addrB_f, addrB_s;
  logic [11:0]   doutB_f = '0, doutB_s = '0;
  logic [AW-1:0] d1_f = '0, d1_s = '0;
  logic          hs_f, vs_f, vblank_f, fs_f;
  logic          hs_s, vs_s, vblank_s, fs_s;
  logic [3:0]    r_f, g_f, b_f, r_s, g_s, b_s;

  int total = 0;
  int bad = 0;
  int n_f = 0;
  int n_s = 0;

  always #5 clk = ~clk;

  vga_fb_scan u_full (
    .clk(clk), .reset(reset_f), .addrB(addrB_f), .doutB(doutB_f),
    .hs(hs_f), .vs(vs_f), .r(r_f), .g(g_f), .b(b_f),
    .vblank(vblank_f), .frame_start(fs_f)
  );

  vga_fb_scan #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .clk(clk), .reset(reset_s), .addrB(addrB_s), .doutB(doutB_s),
    .hs(hs_s), .vs(vs_s), .r(r_s), .g(g_s), .b(b_s),
    .vblank(vblank_s), .frame_start(fs_s)
  );

  // Two-cycle RAM returning the low 12 address bits as data.
  always @(posedge clk) begin
    d1_f    <= addrB_f;
    doutB_f <= d1_f[11:0];
    d1_s    <= addrB_s;
    doutB_s <= d1_s[11:0];
  end

  // Clocks elapsed since reset release.
  always @(posedge clk or negedge reset_f) begin
    if (!reset_f) n_f <= 0;
    else          n_f <= n_f + 1;
  end
  always @(posedge clk or negedge reset_s) begin
    if (!reset_s) n_s <= 0;
    else          n_s <= n_s + 1;
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  function automatic int pix_addr(input int ha, input int va, input int h, input int v);
    if (v >= va) return va * ha - 1;
    if (h >= ha) return v * ha + ha - 1;
    return v * ha + h;
  endfunction

  // Outputs after n clks: pixel p=n/4 is being fetched, outputs show pixel p-1.
  function automatic exp_t model(input int ha, input int hfp, input int hsy, input int hbp,
                                 input int va, input int vfp, input int vsy, input int vbp,
                                 input int n);
    exp_t e;
    int ht, vt, p, q, h, v, ph, pv;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    p  = n / 4;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.addr = AW'(pix_addr(ha, va, h, v));
    if (p == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000; e.vblank = 1'b0;
    end else begin
      q  = p - 1;
      ph = q % ht;
      pv = (q / ht) % vt;
      e.hs     = !(ph >= ha + hfp && ph < ha + hfp + hsy);
      e.vs     = !(pv >= va + vfp && pv < va + vfp + vsy);
      e.rgb    = (ph < ha && pv < va) ? 12'(pix_addr(ha, va, ph, pv)) : 12'h000;
      e.vblank = (pv >= va);
    end
    e.fs = (n > 0) && (n % (4 * ht * vt) == 0);
    return e;
  endfunction

  // Every-clk comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t ef, es, af, as_;
    ef  = model(F_HA, F_HFP, F_HS, F_HBP, F_VA, F_VFP, F_VS, F_VBP, n_f);
    es  = model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, n_s);
    af  = {addrB_f, hs_f, vs_f, r_f, g_f, b_f, vblank_f, fs_f};
    as_ = {addrB_s, hs_s, vs_s, r_s, g_s, b_s, vblank_s, fs_s};
    total += 2;
    if (af !== ef) begin
      bad++;
      $display("FAIL full_model n=%0d act=%h req=%h", n_f, af, ef);
    end
    if (as_ !== es) begin
      bad++;
      $display("FAIL small_model n=%0d act=%h req=%h", n_s, as_, es);
    end
  end

  // Line timing of the full instance: hs period and low width.
  bit hs_prev_f = 1'b1;
  int hs_fall_f = -1;
  always @(negedge clk) begin
    if (!reset_f) begin
      hs_prev_f = 1'b1;
      hs_fall_f = -1;
    end else begin
      if (hs_prev_f && !hs_f) begin
        if (hs_fall_f >= 0) check(n_f - hs_fall_f == 3200, "hs_period", n_f - hs_fall_f, 3200);
        hs_fall_f = n_f;
      end
      if (!hs_prev_f && hs_f && hs_fall_f >= 0)
        check(n_f - hs_fall_f == 384, "hs_low_width", n_f - hs_fall_f, 384);
      hs_prev_f = hs_f;
    end
  end

  // Frame timing of the small instance: vs, vblank and frame_start pulses.
  bit vs_prev_s = 1'b1;
  bit vb_prev_s = 1'b0;
  int vs_fall_s = -1;
  int vb_rise_s = -1;
  int fs_pulses = 0;
  int fs_high   = 0;
  int fs_first  = -1;
  bit fs_prev_s = 1'b0;
  always @(negedge clk) begin
    if (!reset_s) begin
      vs_prev_s = 1'b1; vb_prev_s = 1'b0; fs_prev_s = 1'b0;
      vs_fall_s = -1;   vb_rise_s = -1;
      fs_pulses = 0;    fs_high = 0;    fs_first = -1;
    end else begin
      if (vs_prev_s && !vs_s) begin
        if (vs_fall_s >= 0) check(n_s - vs_fall_s == 600, "vs_period", n_s - vs_fall_s, 600);
        vs_fall_s = n_s;
      end
      if (!vs_prev_s && vs_s && vs_fall_s >= 0)
        check(n_s - vs_fall_s == 120, "vs_low_width", n_s - vs_fall_s, 120);
      if (!vb_prev_s && vblank_s) vb_rise_s = n_s;
      if (vb_prev_s && !vblank_s && vb_rise_s >= 0)
        check(n_s - vb_rise_s == 240, "vblank_width", n_s - vb_rise_s, 240);
      if (n_s <= 1800) begin
        if (fs_s) fs_high++;
        if (fs_s && !fs_prev_s) begin
          fs_pulses++;
          if (fs_first < 0) fs_first = n_s;
        end
      end
      vs_prev_s = vs_s;
      vb_prev_s = vblank_s;
      fs_prev_s = fs_s;
    end
  end

  task automatic wait_f(input int target);
    int guard = 0;
    while (n_f < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (n_f != target) check(1'b0, "wait_full_timeout", n_f, target);
  endtask

  task automatic wait_s(input int target);
    int guard = 0;
    while (n_s < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if (n_s != target) check(1'b0, "wait_small_timeout", n_s, target);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check(!$isunknown({addrB_f, hs_f, vs_f, r_f, g_f, b_f, vblank_f, fs_f}), "reset_no_x", 0, 0);
    check(addrB_f == '0, "reset_addr", int'(addrB_f), 0);
    check(hs_f == 1'b1 && vs_f == 1'b1, "reset_sync", int'({hs_f, vs_f}), 3);
    check({r_f, g_f, b_f} == 12'h000, "reset_rgb", int'({r_f, g_f, b_f}), 0);
    check(vblank_f == 1'b0 && fs_f == 1'b0, "reset_vblank_fs", int'({vblank_f, fs_f}), 0);
    reset_f = 1'b1;
    reset_s = 1'b1;

    fork
      begin
        wait_f(25);
        check({r_f, g_f, b_f} == 12'h005, "rgb_pixel5", int'({r_f, g_f, b_f}), 5);
        wait_f(2557);
        check(addrB_f == AW'(639), "addr_last_line0", int'(addrB_f), 639);
        wait_f(2800);
        check(addrB_f == AW'(639), "addr_hold_hblank", int'(addrB_f), 639);
        check({r_f, g_f, b_f} == 12'h000, "rgb_blank", int'({r_f, g_f, b_f}), 0);
        check(hs_f == 1'b0, "hs_in_sync", int'(hs_f), 0);
        wait_f(3200);
        check(addrB_f == AW'(640), "addr_line1_start", int'(addrB_f), 640);
        wait_f(6420);
        check(addrB_f == AW'(1285), "addr_line2_h5", int'(addrB_f), 1285);
        wait_f(13000);
      end
      begin
        wait_s(202);
        #2;
        reset_s = 1'b0;
        #1;
        check(addrB_s == '0, "async_reset_addr", int'(addrB_s), 0);
        check(hs_s && vs_s, "async_reset_sync", int'({hs_s, vs_s}), 3);
        check({r_s, g_s, b_s, vblank_s, fs_s} == 14'h0, "async_reset_rgb_vb_fs",
              int'({r_s, g_s, b_s, vblank_s, fs_s}), 0);
        repeat (3) @(negedge clk);
        reset_s = 1'b1;
        wait_s(372);
        check(addrB_s == AW'(47), "addr_hold_vblank", int'(addrB_s), 47);
        check(vblank_s == 1'b1, "vblank_high", int'(vblank_s), 1);
        wait_s(600);
        check(addrB_s == '0 && fs_s, "frame_wrap", int'({addrB_s, fs_s}), 1);
        wait_s(1801);
        check(fs_pulses == 3, "fs_pulse_count", fs_pulses, 3);
        check(fs_high == 3, "fs_pulse_width", fs_high, 3);
        check(fs_first == 600, "fs_first_after_release", fs_first, 600);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
